// File: rtl/fibonacci_sequencer_if.sv
// Control and result bundle for fibonacci_sequencer.
// start/busy/done handshake: begin_fibo is sampled only while idle (busy=0) and
// start is accepted on the clock edge that samples it. busy stays high until the
// run completes or aborts. done is a one-cycle pulse with fibo_out and overflow
// valid. term_valid is a one-cycle pulse qualifying term_out and term_index.
// There is no backpressure on any output.
interface fibonacci_sequencer_if #(
  parameter int WIDTH   = 16,
  parameter int N_WIDTH = 5
);
  logic               begin_fibo;
  logic               abort;
  logic [N_WIDTH-1:0] input_s;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   seed0;
  logic [WIDTH-1:0]   seed1;
  logic [WIDTH-1:0]   fibo_out;
  logic               done;
  logic               busy;
  logic               overflow;
  logic               term_valid;
  logic [WIDTH-1:0]   term_out;
  logic [N_WIDTH-1:0] term_index;
  logic               state_dbg;

  modport master (
    output begin_fibo, abort, input_s, mode, seed0, seed1,
    input  fibo_out, done, busy, overflow, term_valid, term_out, term_index, state_dbg
  );

  modport slave (
    input  begin_fibo, abort, input_s, mode, seed0, seed1,
    output fibo_out, done, busy, overflow, term_valid, term_out, term_index, state_dbg
  );
endinterface

// File: rtl/fibonacci_sequencer.sv
// Linear-recurrence engine T(k)=T(k-1)+T(k-2) with selectable seeds; one addition
// per clock, streaming each new term and reporting the final term with an overflow flag.
module fibonacci_sequencer #(
  parameter int WIDTH   = 16,
  parameter int N_WIDTH = 5
) (
  input logic                 clk,
  input logic                 reset,
  fibonacci_sequencer_if.slave bus
);
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COMPUTE = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [N_WIDTH-1:0] r_cnt;
  logic [N_WIDTH-1:0] r_n;
  logic               r_ovf_acc;

  logic [WIDTH-1:0]   r_fibo_out;
  logic               r_overflow;
  logic               r_done;
  logic               r_term_valid;
  logic [WIDTH-1:0]   r_term_out;
  logic [N_WIDTH-1:0] r_term_index;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_t0;
  logic [WIDTH-1:0]   w_t1;
  logic               w_start;
  logic               w_step;
  logic               w_finish;

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_comb begin
    w_t0 = '0;
    w_t1 = WIDTH'(1);
    case (bus.mode)
      2'b01: begin
        w_t0 = WIDTH'(2);
        w_t1 = WIDTH'(1);
      end
      2'b10: begin
        w_t0 = bus.seed0;
        w_t1 = bus.seed1;
      end
      default: begin
        w_t0 = '0;
        w_t1 = WIDTH'(1);
      end
    endcase
  end

  // Abort outranks both the step and the finish decision.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.begin_fibo) begin
          w_start      = 1'b1;
          w_next_state = COMPUTE;
        end
      end
      COMPUTE: begin
        if (bus.abort) begin
          w_next_state = IDLE;
        end else if (r_cnt >= N_WIDTH'(2)) begin
          w_step = 1'b1;
        end else begin
          w_finish     = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_n          <= '0;
      r_ovf_acc    <= 1'b0;
      r_fibo_out   <= '0;
      r_overflow   <= 1'b0;
      r_done       <= 1'b0;
      r_term_valid <= 1'b0;
      r_term_out   <= '0;
      r_term_index <= '0;
    end else begin
      r_done       <= w_finish;
      r_term_valid <= w_step;
      if (w_start) begin
        r_a       <= w_t0;
        r_b       <= w_t1;
        r_cnt     <= bus.input_s;
        r_n       <= bus.input_s;
        r_ovf_acc <= 1'b0;
      end
      if (w_step) begin
        r_a          <= r_b;
        r_b          <= w_sum[WIDTH-1:0];
        r_cnt        <= r_cnt - N_WIDTH'(1);
        r_term_out   <= w_sum[WIDTH-1:0];
        // cnt counts down from n, so the term being produced is n-cnt+2.
        r_term_index <= r_n - r_cnt + N_WIDTH'(2);
        if (w_sum[WIDTH]) begin
          r_ovf_acc <= 1'b1;
        end
      end
      if (w_finish) begin
        r_fibo_out <= (r_cnt == '0) ? r_a : r_b;
        r_overflow <= r_ovf_acc;
      end
    end
  end

  assign bus.fibo_out   = r_fibo_out;
  assign bus.overflow   = r_overflow;
  assign bus.done       = r_done;
  assign bus.busy       = (r_state == COMPUTE);
  assign bus.term_valid = r_term_valid;
  assign bus.term_out   = r_term_out;
  assign bus.term_index = r_term_index;
  assign bus.state_dbg  = (r_state == COMPUTE);
endmodule
